// File: rtl/prio_encode8to3_db.sv
// Debounced 8-to-3 priority encoder with a held-event register for a polling consumer.
// Raw levels are synchronized and debounced, then encoded, and each change of (valid, code) is latched.
module prio_encode8to3_db #(
    parameter int DB_COUNT = 1_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in,
    input  logic       ack,
    output logic [2:0] code,
    output logic       valid,
    output logic       chg,
    output logic       evt_pend,
    output logic [2:0] evt_code,
    output logic       evt_valid,
    output logic       ovr
);

    localparam int CNT_W = $clog2(DB_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_COUNT - 1);

    typedef enum logic {
        STABLE,
        WAIT
    } state_t;

    state_t           state, state_n;
    logic [7:0]       sync1, sync2;
    logic [7:0]       cand, cand_n;
    logic [7:0]       stable, stable_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       code_n;
    logic             valid_n;
    logic             chg_n;

    // Bit 7 has the highest priority; the highest set bit is the last one the loop sees.
    function automatic logic [2:0] enc_code(input logic [7:0] v);
        enc_code = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) enc_code = 3'(i);
        end
    endfunction

    always_comb begin
        state_n  = state;
        cand_n   = cand;
        stable_n = stable;
        cnt_n    = cnt;
        case (state)
            STABLE: begin
                if (sync2 != stable) begin
                    cand_n  = sync2;
                    cnt_n   = '0;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (sync2 == cand) begin
                    if (cnt >= CNT_MAX) begin
                        stable_n = cand;
                        state_n  = STABLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else if (sync2 == stable) begin
                    // Input fell back to the accepted value: a glitch, nothing to report.
                    state_n = STABLE;
                end else begin
                    cand_n = sync2;
                    cnt_n  = '0;
                end
            end
            default: state_n = STABLE;
        endcase
    end

    always_comb begin
        code_n  = enc_code(stable);
        valid_n = |stable;
        chg_n   = ({valid_n, code_n} != {valid, code});
    end

    // Synchronizer -> debounce -> encoder output / event hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= '0;
            sync2     <= '0;
            state     <= STABLE;
            cand      <= '0;
            stable    <= '0;
            cnt       <= '0;
            code      <= '0;
            valid     <= 1'b0;
            chg       <= 1'b0;
            evt_pend  <= 1'b0;
            evt_code  <= '0;
            evt_valid <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            sync1  <= in;
            sync2  <= sync1;
            state  <= state_n;
            cand   <= cand_n;
            stable <= stable_n;
            cnt    <= cnt_n;
            code   <= code_n;
            valid  <= valid_n;
            chg    <= chg_n;
            if (chg_n) begin
                // A new event always wins; an ack in the same cycle consumes the old one.
                evt_pend  <= 1'b1;
                evt_code  <= code_n;
                evt_valid <= valid_n;
                if (ack)           ovr <= 1'b0;
                else if (evt_pend) ovr <= 1'b1;
            end else if (ack && evt_pend) begin
                evt_pend <= 1'b0;
                ovr      <= 1'b0;
            end
        end
    end

endmodule
